// File: rtl/window_gen.sv
// window_gen: raster pixel stream to sliding KERNEL_W x KERNEL_W window for conv
module window_gen #(
   parameter int DATA_W   = 8,
   parameter int KERNEL_W = 3,
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   localparam int CW      = $clog2(IMG_W),
   localparam int RW      = $clog2(IMG_H)
) (
   input  logic                                          clk_i,
   input  logic                                          rst_i,
   input  logic [DATA_W-1:0]                             pixel_i,
   input  logic                                          pixel_valid_i,
   input  logic                                          sof_i,
   output logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] window_o,
   output logic                                          window_valid_o,
   output logic [CW-1:0]                                 col_o,
   output logic [RW-1:0]                                 row_o
);
   logic [CW-1:0] col, cur_col, nxt_col, s1_col, s2_col;
   logic [RW-1:0] row, cur_row, nxt_row, s1_row, s2_row;
   logic s1_valid, s1_ok, s2_ok;
   logic [DATA_W-1:0] lb [KERNEL_W-1][IMG_W];
   logic [KERNEL_W-1:0][DATA_W-1:0] s1_data;
   logic [KERNEL_W-1:0][KERNEL_W-1:0][DATA_W-1:0] win;
   // position of the pixel being accepted (sof forces origin) and of the one after it
   always_comb begin
      cur_col = sof_i ? '0 : col;
      cur_row = sof_i ? '0 : row;
      nxt_col = (cur_col == CW'(IMG_W-1)) ? '0 : cur_col + 1'b1;
      nxt_row = (cur_col != CW'(IMG_W-1)) ? cur_row :
                (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + 1'b1;
   end
   // counters, valid pipeline and output registers; outputs load only on a pulse so they hold between pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col            <= '0;
         row            <= '0;
         s1_valid       <= 1'b0;
         s1_ok          <= 1'b0;
         s1_col         <= '0;
         s1_row         <= '0;
         s2_ok          <= 1'b0;
         s2_col         <= '0;
         s2_row         <= '0;
         window_valid_o <= 1'b0;
         window_o       <= '0;
         col_o          <= '0;
         row_o          <= '0;
      end else begin
         s1_valid       <= pixel_valid_i;
         s2_ok          <= s1_valid && s1_ok;
         window_valid_o <= s2_ok;
         if (pixel_valid_i) begin
            col    <= nxt_col;
            row    <= nxt_row;
            s1_col <= cur_col;
            s1_row <= cur_row;
            s1_ok  <= (cur_col >= CW'(KERNEL_W-1)) && (cur_row >= RW'(KERNEL_W-1));
         end
         if (s1_valid) begin
            s2_col <= s1_col;
            s2_row <= s1_row;
         end
         if (s2_ok) begin
            window_o <= win;
            col_o    <= s2_col;
            row_o    <= s2_row;
         end
      end
   end
   // line buffers cascade at the current column; reads return pre-write data to build the new column
   always_ff @(posedge clk_i) begin
      if (pixel_valid_i) begin
         s1_data[0]       <= pixel_i;
         lb[0][cur_col]   <= pixel_i;
         for (int n = 1; n < KERNEL_W-1; n++) lb[n][cur_col] <= lb[n-1][cur_col];
         for (int n = 0; n < KERNEL_W-1; n++) s1_data[n+1] <= lb[n][cur_col];
      end
   end
   // window shift register: the new column enters at c=0, only when a pixel moves through
   always_ff @(posedge clk_i) begin
      if (s1_valid)
         for (int r = 0; r < KERNEL_W; r++) win[r] <= {win[r][KERNEL_W-2:0], s1_data[r]};
   end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized scoreboard bench for window_gen against a frame-array model
module tb_window_gen;
   localparam int DW = 8, K = 3, W = 4, H = 4;
   typedef logic [K-1:0][K-1:0][DW-1:0] win_t;
   typedef struct {win_t w; int c; int r; int due;} exp_t;
   logic clk = 0, rst = 0;
   logic [DW-1:0] pixel_i = '0;
   logic pixel_valid_i = 0, sof_i = 0;
   win_t window_o;
   logic window_valid_o;
   logic [$clog2(W)-1:0] col_o;
   logic [$clog2(H)-1:0] row_o;
   exp_t q[$];
   exp_t e;
   int cyc = 0, vectors = 0, miscompares = 0;
   logic [DW-1:0] img [H][W];
   int pr = 0, pc = 0;
   win_t last_w = '0;
   int last_c = 0, last_r = 0;
   bit mon_on = 0;

   window_gen #(.DATA_W(DW), .KERNEL_W(K), .IMG_W(W), .IMG_H(H)) dut (
      .clk_i(clk), .rst_i(rst), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
      .sof_i(sof_i), .window_o(window_o), .window_valid_o(window_valid_o),
      .col_o(col_o), .row_o(row_o));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   // reference: store the frame by coordinates, window[i][j] = pixel at (row-i, col-j)
   task automatic accept(input logic [DW-1:0] p, input bit s);
      win_t w;
      if (s) begin pr = 0; pc = 0; end
      img[pr][pc] = p;
      if (pr >= K-1 && pc >= K-1) begin
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) w[i][j] = img[pr-i][pc-j];
         q.push_back('{w, pc, pr, cyc + 3});
      end
      pc++;
      if (pc == W) begin pc = 0; pr = (pr + 1) % H; end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
         pixel_valid_i = 0;
         sof_i = 1'($urandom_range(0, 1));
         pixel_i = DW'($urandom);
      end
   endtask

   task automatic drive(input logic [DW-1:0] p, input bit s, input int gap);
      @(posedge clk); #2;
      pixel_i = p; pixel_valid_i = 1; sof_i = s;
      accept(p, s);
      idle(gap);
   endtask

   task automatic frame(input int base, input bit s, input int gmax);
      for (int k = 0; k < W*H; k++) drive(DW'(base + k), s && k == 0, $urandom_range(0, gmax));
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1; pixel_valid_i = 0; sof_i = 0;
      q.delete();
      last_w = '0; last_c = 0; last_r = 0;
      pr = 0; pc = 0; mon_on = 1;
      @(posedge clk); #2;
      rst = 0;
   endtask

   // monitor: one check per edge, pops expected windows when a pulse appears
   initial forever begin
      @(posedge clk); #1;
      cyc++;
      if (mon_on) begin
         if (window_valid_o) begin
            if (q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_pulse at cycle %0d: got 1 want 0", cyc);
            end else begin
               e = q.pop_front();
               chk("window", window_o, e.w);
               chk("col", 72'(col_o), 72'(e.c));
               chk("row", 72'(row_o), 72'(e.r));
               chk("latency", 72'(cyc), 72'(e.due));
               last_w = e.w; last_c = e.c; last_r = e.r;
            end
         end else begin
            chk("hold_window", window_o, last_w);
            chk("hold_col", 72'(col_o), 72'(last_c));
            chk("hold_row", 72'(row_o), 72'(last_r));
            if (q.size() > 0 && q[0].due <= cyc) begin
               vectors++; miscompares++;
               $display("FAIL missing_pulse at cycle %0d: got 0 want 1 (due %0d)", cyc, q[0].due);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      do_reset();
      frame(0, 1, 0);
      idle(5);
      frame(0, 1, 5);
      idle(5);
      frame(0, 1, 0);
      frame(100, 1, 0);
      idle(5);
      for (int k = 0; k < 7; k++) drive(DW'(50 + k), k == 0, 0);
      frame(200, 1, 0);
      idle(5);
      for (int k = 0; k < 7; k++) drive(DW'(k), k == 0, 0);
      do_reset();
      idle(1);
      frame(0, 0, 0);
      idle(5);
      frame(0, 1, 0);
      frame(0, 0, 0);
      frame(100, 0, 2);
      idle(3);
      for (int i = 0; i < 200; i++)
         drive(DW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2));
      idle(10);
      chk("drained", 72'(q.size()), 72'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
